// File: rtl/lcd_wave_scope.sv
// lcd_wave_scope: triggered, double-buffered waveform renderer for the
// 1024x600 LCD path. One record of H_ACTIVE samples is captured after an
// edge trigger into the back bank and swapped to the front bank at frame
// start. Grid, axes, a thick connected trace and a text overlay are rendered
// into registered RGB888 with a fixed 2-cycle latency.
// Optional feature macro: TRIG_MARKER_EN (dashed trigger-level line plus a
// vertical marker at column 0 of the plot area).
module lcd_wave_scope #(
    parameter int          H_ACTIVE   = 1024,
    parameter int          SAMPLE_W   = 8,
    parameter int          WAVE_Y_TOP = 0,
    parameter int          GRID_STEP  = 50,
    parameter int          LINE_THICK = 3,
    parameter logic [23:0] WAVE_COLOR = 24'h00FF00,
    parameter logic [23:0] GRID_COLOR = 24'h404040
) (
    input  logic                lcd_pclk,
    input  logic                rst_n,
    input  logic [10:0]         pixel_xpos,
    input  logic [9:0]          pixel_ypos,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_falling,
    input  logic                run,
    input  logic                text_on,
    output logic [23:0]         pixel_data,
    output logic                capture_busy,
    output logic                swap_pulse
);

    localparam int              AW       = $clog2(H_ACTIVE);
    localparam int              PLOT_MAX = (1 << SAMPLE_W) - 1;
    localparam logic [10:0]     Y_TOP    = 11'(WAVE_Y_TOP);
    localparam logic [10:0]     Y_SPAN   = 11'(PLOT_MAX);
    localparam logic [10:0]     THICK    = 11'(LINE_THICK);
    localparam logic [10:0]     H_LIM    = 11'(H_ACTIVE);
    localparam logic [10:0]     G_STEP   = 11'(GRID_STEP);
    localparam logic [AW-1:0]   COL_LAST = AW'(H_ACTIVE - 1);
    localparam logic [23:0]     WHITE    = 24'hFFFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                state, state_nx;
    logic [SAMPLE_W-1:0]   mem [0:(2**(AW+1))-1];
    logic [AW-1:0]         wr_addr, wr_addr_nx, wr_idx;
    logic                  wr_en;
    logic                  front_bank, disp_valid;
    logic [SAMPLE_W-1:0]   last_s;
    logic                  have_last;
    logic                  trig_hit, frame_start, swap_now;
    logic                  rd_bank;
    logic [AW-1:0]         rd_col;

    logic [SAMPLE_W-1:0]   rd_data;
    logic [10:0]           x_d1;
    logic [9:0]            y_d1;
    logic                  txt_d1, dv_d1;
    logic [10:0]           y_ext, y_cur, y_cur_q, y_prev, y_lo, y_hi;
    logic                  on_grid;
    logic [23:0]           colour;

    assign frame_start  = (pixel_xpos == '0) && (pixel_ypos == '0);
    assign capture_busy = (state == S_ARMED) || (state == S_CAPTURE);

    // Edge detect against the previous valid sample; never fires before one exists.
    always_comb begin
        trig_hit = 1'b0;
        if (sample_valid && have_last) begin
            if (trig_falling)
                trig_hit = (last_s > trig_level) && (sample_in <= trig_level);
            else
                trig_hit = (last_s < trig_level) && (sample_in >= trig_level);
        end
    end

    // Acquisition next-state, back-bank write control and swap request.
    always_comb begin
        state_nx   = state;
        wr_addr_nx = wr_addr;
        wr_en      = 1'b0;
        wr_idx     = wr_addr;
        swap_now   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (run) state_nx = S_ARMED;
            end
            S_ARMED: begin
                if (!run) begin
                    state_nx = S_IDLE;
                end else if (trig_hit) begin
                    wr_en      = 1'b1;
                    wr_idx     = '0;
                    wr_addr_nx = AW'(1);
                    state_nx   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!run) begin
                    state_nx = S_IDLE;
                end else if (sample_valid) begin
                    wr_en      = 1'b1;
                    wr_addr_nx = wr_addr + 1'b1;
                    if (wr_addr == COL_LAST) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                if (frame_start) begin
                    swap_now = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Acquisition state, bank ownership and last-sample history.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_addr    <= '0;
            front_bank <= 1'b0;
            disp_valid <= 1'b0;
            swap_pulse <= 1'b0;
            last_s     <= '0;
            have_last  <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_addr    <= wr_addr_nx;
            swap_pulse <= swap_now;
            if (swap_now) begin
                front_bank <= ~front_bank;
                disp_valid <= 1'b1;
            end
            if (sample_valid) begin
                last_s    <= sample_in;
                have_last <= 1'b1;
            end
        end
    end

    // The read in the swap cycle already targets the new front bank so the
    // first pixel of the new frame comes from the fresh record.
    assign rd_bank = front_bank ^ swap_now;
    assign rd_col  = (pixel_xpos >= H_LIM) ? COL_LAST : pixel_xpos[AW-1:0];

    // Dual-bank sample RAM: write the back bank, read the front bank.
    always_ff @(posedge lcd_pclk) begin
        if (wr_en) mem[{~front_bank, wr_idx}] <= sample_in;
        rd_data <= mem[{rd_bank, rd_col}];
    end

    // Stage 0: delay coordinates, overlay and display-valid alongside the read.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_d1   <= '0;
            y_d1   <= '0;
            txt_d1 <= 1'b0;
            dv_d1  <= 1'b0;
        end else begin
            x_d1   <= pixel_xpos;
            y_d1   <= pixel_ypos;
            txt_d1 <= text_on;
            dv_d1  <= disp_valid | swap_now;
        end
    end

    assign y_ext   = {1'b0, y_d1};
    assign y_cur   = Y_TOP + Y_SPAN - 11'(rd_data);
    assign y_prev  = (x_d1 == '0) ? y_cur : y_cur_q;
    assign y_lo    = (y_prev < y_cur) ? y_prev : y_cur;
    assign y_hi    = (y_prev < y_cur) ? y_cur : y_prev;
    assign on_grid = ((x_d1 % G_STEP) == '0) || ((y_ext % G_STEP) == '0);

`ifdef TRIG_MARKER_EN
    logic [SAMPLE_W-1:0] trig_lvl_q;
    logic [10:0]         mark_y;
    logic                marker_hit;

    // Trigger level shown with the record it produced, latched at each swap.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n)        trig_lvl_q <= '0;
        else if (swap_now) trig_lvl_q <= trig_level;
    end

    assign mark_y     = Y_TOP + Y_SPAN - 11'(trig_lvl_q);
    assign marker_hit = ((y_ext == mark_y) && !x_d1[2]) ||
                        ((x_d1 == '0) && (y_ext >= Y_TOP) && (y_ext <= Y_TOP + Y_SPAN));
`endif

    // Stage 1: layer colours from lowest to highest priority.
    always_comb begin
        colour = '0;
        if (on_grid) colour = GRID_COLOR;
        if ((x_d1 == '0) || (y_ext == Y_TOP)) colour = WHITE;
        if (dv_d1 && (x_d1 < H_LIM) && (y_ext + THICK >= y_lo) && (y_ext <= y_hi + THICK))
            colour = WAVE_COLOR;
`ifdef TRIG_MARKER_EN
        if (marker_hit) colour = 24'hFFFF00;
`endif
        if (txt_d1) colour = WHITE;
    end

    // Stage 2: register the pixel and remember this column's trace row.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data <= '0;
            y_cur_q    <= '0;
        end else begin
            pixel_data <= colour;
            y_cur_q    <= y_cur;
        end
    end

endmodule

// File: tb/tb_lcd_wave_scope.sv
// Bench for lcd_wave_scope: a reference model built from the acquisition and
// drawing rules (record queue, displayed record array, per-pixel colour rule)
// runs alongside the DUT and checks every cycle, plus a table of fixed pixels
// and hand-written capture/swap/freeze/overlay sequences.
module tb_lcd_wave_scope;
    localparam int          H     = 1024;
    localparam int          YTOP  = 0;
    localparam int          GS    = 50;
    localparam int          LT    = 3;
    localparam int          SMAX  = 255;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] GRID  = 24'h404040;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BLACK = 24'h000000;

    logic        lcd_pclk     = 1'b0;
    logic        rst_n        = 1'b0;
    logic [10:0] pixel_xpos   = '0;
    logic [9:0]  pixel_ypos   = '0;
    logic [7:0]  sample_in    = '0;
    logic        sample_valid = 1'b0;
    logic [7:0]  trig_level   = 8'd128;
    logic        trig_falling = 1'b0;
    logic        run          = 1'b0;
    logic        text_on      = 1'b0;
    logic [23:0] pixel_data;
    logic        capture_busy;
    logic        swap_pulse;

    lcd_wave_scope #(
        .H_ACTIVE  (H),
        .SAMPLE_W  (8),
        .WAVE_Y_TOP(YTOP),
        .GRID_STEP (GS),
        .LINE_THICK(LT)
    ) dut (
        .lcd_pclk    (lcd_pclk),
        .rst_n       (rst_n),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .trig_level  (trig_level),
        .trig_falling(trig_falling),
        .run         (run),
        .text_on     (text_on),
        .pixel_data  (pixel_data),
        .capture_busy(capture_busy),
        .swap_pulse  (swap_pulse)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: phase 0 idle, 1 armed, 2 capturing, 3 record complete.
    int    m_phase = 0;
    int    cap[$];
    int    fr[H];
    bit    m_dv = 0, m_swap = 0, m_have = 0;
    int    m_last = 0, m_lvl = 0;
    logic [23:0] exp_q = '0;
    bit    exp_v = 0;
    bit    h0_v = 0, h1_v = 0;
    logic [23:0] h0_val = '0, h1_val = '0;
    string h0_nm = "", h1_nm = "";
    int    swaps = 0;

    task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int ycol(input int v);
        return YTOP + SMAX - v;
    endfunction

    function automatic logic [23:0] ref_color(input int x, input int y, input bit t);
        logic [23:0] c;
        int cur, prev, lo, hi;
        c = BLACK;
        if ((x % GS) == 0 || (y % GS) == 0) c = GRID;
        if (x == 0 || y == YTOP) c = WHITE;
        if (m_dv && x < H) begin
            cur  = ycol(fr[x]);
            prev = (x == 0) ? cur : ycol(fr[x-1]);
            lo   = (cur < prev) ? cur : prev;
            hi   = (cur < prev) ? prev : cur;
            if (y + LT >= lo && y <= hi + LT) c = GREEN;
        end
`ifdef TRIG_MARKER_EN
        if ((y == YTOP + SMAX - m_lvl && (x & 4) == 0) || (x == 0 && y >= YTOP && y <= YTOP + SMAX))
            c = 24'hFFFF00;
`endif
        if (t) c = WHITE;
        return c;
    endfunction

    task automatic model_edge();
        int  s, lvl;
        bit  v, trig;
        s    = int'(sample_in);
        lvl  = int'(trig_level);
        v    = sample_valid;
        trig = v && m_have && (trig_falling ? (m_last > lvl && s <= lvl) : (m_last < lvl && s >= lvl));
        m_swap = 0;
        case (m_phase)
            0: if (run) m_phase = 1;
            1: begin
                if (!run) m_phase = 0;
                else if (trig) begin
                    cap.delete();
                    cap.push_back(s);
                    m_phase = 2;
                end
            end
            2: begin
                if (!run) m_phase = 0;
                else if (v) begin
                    cap.push_back(s);
                    if (cap.size() == H) m_phase = 3;
                end
            end
            default: begin
                if (pixel_xpos == 0 && pixel_ypos == 0) begin
                    for (int i = 0; i < H; i++) fr[i] = cap[i];
                    m_dv    = 1;
                    m_swap  = 1;
                    m_lvl   = lvl;
                    m_phase = 0;
                end
            end
        endcase
        if (v) begin
            m_last = s;
            m_have = 1;
        end
    endtask

    task automatic mark(input string nm, input logic [23:0] v);
        h0_v   = 1;
        h0_val = v;
        h0_nm  = nm;
    endtask

    task automatic cyc();
        logic [23:0] e;
        @(posedge lcd_pclk);
        model_edge();
        e = ref_color(int'(pixel_xpos), int'(pixel_ypos), text_on);
        #1;
        check("capture_busy", {23'b0, capture_busy}, {23'b0, (m_phase == 1 || m_phase == 2)});
        check("swap_pulse", {23'b0, swap_pulse}, {23'b0, m_swap});
        if (swap_pulse) swaps++;
        if (exp_v) check("pixel_data", pixel_data, exp_q);
        if (h1_v) check(h1_nm, pixel_data, h1_val);
        h1_v   = h0_v;
        h1_val = h0_val;
        h1_nm  = h0_nm;
        h0_v   = 0;
        exp_q  = e;
        exp_v  = 1;
    endtask

    task automatic park();
        pixel_xpos = 11'd1100;
        pixel_ypos = 10'd599;
        text_on    = 1'b0;
    endtask

    task automatic flush();
        park();
        sample_valid = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic do_reset();
        @(negedge lcd_pclk);
        rst_n   = 1'b0;
        m_phase = 0;
        m_dv    = 0;
        m_have  = 0;
        m_swap  = 0;
        m_lvl   = 0;
        exp_v   = 0;
        h0_v    = 0;
        h1_v    = 0;
        cap.delete();
        #1;
        check("reset_pixel", pixel_data, BLACK);
        check("reset_busy", {23'b0, capture_busy}, 24'd0);
        check("reset_swap", {23'b0, swap_pulse}, 24'd0);
        repeat (2) @(posedge lcd_pclk);
        @(negedge lcd_pclk);
        rst_n = 1'b1;
    endtask

    task automatic scan_row(input int row, input int xlast, input int markx,
                            input logic [23:0] mexp, input string nm, input int txtx);
        for (int xx = 0; xx <= xlast; xx++) begin
            pixel_xpos = 11'(xx);
            pixel_ypos = 10'(row);
            text_on    = (xx == txtx);
            if (xx == markx) mark(nm, mexp);
            cyc();
        end
        text_on = 1'b0;
    endtask

    typedef struct {
        int          x;
        int          y;
        bit          t;
        logic [23:0] exp;
        string       nm;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int sw0, rx, ry, rowcnt;

        tbl[0] = '{0,    5,   1'b0, WHITE, "axis_col0"};
        tbl[1] = '{50,   7,   1'b0, GRID,  "grid_col50"};
        tbl[2] = '{13,   7,   1'b0, BLACK, "background"};
        tbl[3] = '{100,  0,   1'b0, WHITE, "axis_row0"};
        tbl[4] = '{7,    100, 1'b0, GRID,  "grid_row100"};
        tbl[5] = '{1000, 3,   1'b0, GRID,  "grid_col1000"};
        tbl[6] = '{1023, 599, 1'b0, BLACK, "background_corner"};
        tbl[7] = '{1030, 13,  1'b0, BLACK, "beyond_active"};
        tbl[8] = '{13,   7,   1'b1, WHITE, "text_on_bg"};

        // Reset, run with no samples: static scene only, no swap.
        park();
        do_reset();
        run = 1'b1;
        repeat (4) cyc();
        check("armed_busy", {23'b0, capture_busy}, 24'd1);
        for (int i = 0; i < 9; i++) begin
            pixel_xpos = 11'(tbl[i].x);
            pixel_ypos = 10'(tbl[i].y);
            text_on    = tbl[i].t;
            mark(tbl[i].nm, tbl[i].exp);
            cyc();
        end
        flush();
        check("no_swap_idle", 24'(swaps), 24'd0);

        // Rising ramp through 128: record starts with 128, column 0 at y=127.
        sample_valid = 1'b1;
        for (int i = 0; i < 1400; i++) begin
            sample_in = 8'(i & 255);
            cyc();
            if (i > 130 && !capture_busy) break;
        end
        check("ramp_capture_done", {23'b0, capture_busy}, 24'd0);
        sample_valid = 1'b0;
        sw0 = swaps;
        pixel_xpos = '0;
        pixel_ypos = '0;
        cyc();
        for (int r = 120; r <= 134; r++) begin
            pixel_xpos = '0;
            pixel_ypos = 10'(r);
            mark("ramp_col0", (r >= 124 && r <= 130) ? GREEN : WHITE);
            cyc();
        end
        flush();
        check("ramp_one_swap", 24'(swaps - sw0), 24'd1);

        // Falling trigger on a single rising ramp pass: stays armed, nothing drawn.
        park();
        do_reset();
        trig_falling = 1'b1;
        trig_level   = 8'd128;
        run          = 1'b1;
        sw0          = swaps;
        sample_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sample_in = 8'(i);
            cyc();
        end
        sample_valid = 1'b0;
        check("fall_still_armed", {23'b0, capture_busy}, 24'd1);
        pixel_xpos = '0;
        pixel_ypos = '0;
        cyc();
        pixel_xpos = 11'd13;
        pixel_ypos = 10'd127;
        mark("fall_no_trace", BLACK);
        cyc();
        pixel_xpos = 11'd0;
        mark("fall_col0_axis", WHITE);
        cyc();
        flush();
        check("fall_no_swap", 24'(swaps - sw0), 24'd0);

        // Square wave 0/255: full-height connecting segment at column 64.
        park();
        do_reset();
        trig_falling = 1'b0;
        trig_level   = 8'd128;
        run          = 1'b1;
        sample_valid = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            sample_in = ((i / 64) % 2 == 1) ? 8'd255 : 8'd0;
            cyc();
            if (i > 70 && !capture_busy) break;
        end
        check("square_capture_done", {23'b0, capture_busy}, 24'd0);
        sample_valid = 1'b0;
        pixel_xpos = '0;
        pixel_ypos = '0;
        cyc();
        scan_row(0,   64, 64, GREEN, "square_row0",   -1);
        scan_row(100, 64, 64, GREEN, "square_row100", -1);
        scan_row(258, 64, 64, GREEN, "square_row258", -1);
        scan_row(259, 64, 64, BLACK, "square_row259", -1);
        scan_row(310, 80, 80, WHITE, "text_at_80_310", 80);
        scan_row(200, 64, 64, WHITE, "text_over_trace", 64);
        flush();

        // Freeze: run low, new samples, three frames unchanged.
        run = 1'b0;
        sw0 = swaps;
        for (int f = 0; f < 3; f++) begin
            sample_valid = 1'b1;
            for (int xx = 0; xx <= 1039; xx++) begin
                pixel_xpos = 11'(xx);
                pixel_ypos = '0;
                sample_in  = 8'($urandom);
                if (xx == 64) mark("freeze_row0", GREEN);
                cyc();
            end
            sample_valid = 1'b0;
            scan_row(200, 100, 64, GREEN, "freeze_row200", -1);
        end
        flush();
        check("freeze_busy", {23'b0, capture_busy}, 24'd0);
        check("freeze_no_swap", 24'(swaps - sw0), 24'd0);

        // Randomized raster with random samples, levels and run toggles.
        park();
        do_reset();
        trig_level   = 8'($urandom_range(40, 215));
        trig_falling = 1'($urandom_range(0, 1));
        run          = 1'b1;
        sw0          = swaps;
        rx = 0;
        ry = 0;
        rowcnt = 0;
        for (int c = 0; c < 24000; c++) begin
            pixel_xpos   = 11'(rx);
            pixel_ypos   = 10'(ry);
            text_on      = ($urandom_range(0, 63) == 0);
            sample_valid = ($urandom_range(0, 3) != 0);
            sample_in    = 8'($urandom);
            if ($urandom_range(0, 4999) == 0) run = ~run;
            cyc();
            rx++;
            if (rx == 1040) begin
                rx = 0;
                rowcnt++;
                ry = (rowcnt % 4 == 0) ? 0 : $urandom_range(1, 599);
                if (rowcnt % 8 == 0) begin
                    trig_level   = 8'($urandom_range(40, 215));
                    trig_falling = 1'($urandom_range(0, 1));
                    run          = 1'b1;
                end
            end
        end
        flush();
        check("random_swaps_seen", {23'b0, (swaps - sw0) > 0}, 24'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "time limit reached");
    end

endmodule
